tlul_xbar_1ton: RTL and testbench

// Parametrised TL-UL 1-to-N address demux; successor to the fixed two-device data-side fabric.

---
 rtl/tlul_xbar_1ton.sv | 155 +++++++++++++++
 tb/tb_tlul_xbar_1ton.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_xbar_1ton.sv
// TL-UL 1-to-N address demux with in-order response return, bounded outstanding
// requests and an internal error responder for unmapped addresses.
typedef struct packed {
   logic        a_valid;
   logic [2:0]  a_opcode;
   logic [2:0]  a_param;
   logic [1:0]  a_size;
   logic [7:0]  a_source;
   logic [31:0] a_address;
   logic [3:0]  a_mask;
   logic [31:0] a_data;
   logic [13:0] a_user;
   logic        d_ready;
} tl_h2d_t;

typedef struct packed {
   logic        d_valid;
   logic [2:0]  d_opcode;
   logic [2:0]  d_param;
   logic [1:0]  d_size;
   logic [7:0]  d_source;
   logic        d_sink;
   logic [31:0] d_data;
   logic [13:0] d_user;
   logic        d_error;
   logic        a_ready;
} tl_d2h_t;

module tlul_xbar_1ton #(
   parameter int unsigned NumDev         = 4,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned DevBase [NumDev] = '{32'h1000_0000, 32'h2000_0000, 32'h4000_0000, 32'h5000_0000},
   parameter int unsigned DevMask [NumDev] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  tl_h2d_t                               tl_h_i,
   output tl_d2h_t                               tl_h_o,
   output tl_h2d_t                               tl_d_o [NumDev],
   input  tl_d2h_t                               tl_d_i [NumDev],
   output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
   output logic                                  unmapped_o
);

   localparam int unsigned CW = $clog2(MaxOutstanding + 1);
   localparam int unsigned SW = $clog2(NumDev + 1);
   localparam logic [SW-1:0] ERR = SW'(NumDev);
   localparam logic [2:0] OP_GET = 3'd4;
   localparam logic [2:0] OP_ACK = 3'd0;
   localparam logic [2:0] OP_ACK_DATA = 3'd1;
   localparam logic [63:0] K_MASK [7] = '{
      64'h0000_0000_FF00_FF0F, 64'h0000_00FF_00FF_F0F0, 64'h0000_FF00_FF0F_0F33,
      64'h00FF_00FF_0FF0_33CC, 64'hFF00_FF0F_F00F_CC55, 64'h00FF_F0F0_33CC_55AA,
      64'hFF0F_0F33_CC55_AA96};

   logic [CW-1:0] r_cnt;
   logic [SW-1:0] r_sel;
   logic          r_err_pend;
   logic          r_err_get;
   logic [1:0]    r_err_size;
   logic [7:0]    r_err_src;

   logic [SW-1:0] w_tgt;
   logic          w_hit;
   logic          w_dev_rdy;
   logic          w_a_ready;
   logic          w_accept;
   logic          w_d_valid;
   logic          w_complete;
   tl_d2h_t       w_err_rsp;
   tl_d2h_t       w_rsp;

   function automatic logic [6:0] f_intg(input logic [63:0] d);
      logic [6:0] p;
      for (int unsigned k = 0; k < 7; k++) p[k] = ^(d & K_MASK[k]);
      return p;
   endfunction

   // Lowest-indexed matching window wins; no match routes to the error responder.
   always_comb begin
      w_tgt = ERR;
      w_hit = 1'b0;
      for (int unsigned i = 0; i < NumDev; i++) begin
         if (!w_hit && ((tl_h_i.a_address & DevMask[i]) == DevBase[i])) begin
            w_tgt = SW'(i);
            w_hit = 1'b1;
         end
      end
   end

   always_comb begin
      w_dev_rdy = !r_err_pend;
      for (int unsigned i = 0; i < NumDev; i++) begin
         if (w_tgt == SW'(i)) w_dev_rdy = tl_d_i[i].a_ready;
      end
      w_a_ready = !rst_i && (r_cnt != CW'(MaxOutstanding)) &&
                  !((r_cnt != '0) && (w_tgt != r_sel)) && w_dev_rdy;
      w_accept  = tl_h_i.a_valid && w_a_ready;
   end

   always_comb begin
      w_err_rsp          = '0;
      w_err_rsp.d_valid  = r_err_pend;
      w_err_rsp.d_opcode = r_err_get ? OP_ACK_DATA : OP_ACK;
      w_err_rsp.d_size   = r_err_size;
      w_err_rsp.d_source = r_err_src;
      w_err_rsp.d_data   = '1;
      w_err_rsp.d_error  = 1'b1;
      w_err_rsp.d_user   = {f_intg({55'd0, w_err_rsp.d_opcode, w_err_rsp.d_size, 1'b0, 1'b1, 2'b00}),
                            f_intg({32'd0, w_err_rsp.d_data})};
      w_rsp = w_err_rsp;
      for (int unsigned i = 0; i < NumDev; i++) begin
         if (r_sel == SW'(i)) w_rsp = tl_d_i[i];
      end
      // d_valid gated by the count so stale responses after reset never complete.
      w_d_valid        = w_rsp.d_valid && (r_cnt != '0);
      w_complete       = w_d_valid && tl_h_i.d_ready;
      tl_h_o           = w_rsp;
      tl_h_o.d_valid   = w_d_valid;
      tl_h_o.a_ready   = w_a_ready;
   end

   always_comb begin
      for (int unsigned i = 0; i < NumDev; i++) begin
         tl_d_o[i]         = tl_h_i;
         tl_d_o[i].a_valid = w_accept && (w_tgt == SW'(i));
         tl_d_o[i].d_ready = tl_h_i.d_ready && (r_sel == SW'(i)) && (r_cnt != '0);
      end
      outstanding_o = r_cnt;
      unmapped_o    = w_accept && (w_tgt == ERR);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt      <= '0;
         r_sel      <= '0;
         r_err_pend <= 1'b0;
         r_err_get  <= 1'b0;
         r_err_size <= '0;
         r_err_src  <= '0;
      end else begin
         if (w_accept && !w_complete) r_cnt <= r_cnt + CW'(1);
         else if (!w_accept && w_complete) r_cnt <= r_cnt - CW'(1);
         if (w_accept) r_sel <= w_tgt;
         if (w_complete && (r_sel == ERR)) r_err_pend <= 1'b0;
         if (w_accept && (w_tgt == ERR)) begin
            r_err_pend <= 1'b1;
            r_err_get  <= (tl_h_i.a_opcode == OP_GET);
            r_err_size <= tl_h_i.a_size;
            r_err_src  <= tl_h_i.a_source;
         end
      end
   end

endmodule

// File: tb/tb_tlul_xbar_1ton.sv
// Directed bench for tlul_xbar_1ton: routing, stalls, ordering, error responder, reset.
module tb_tlul_xbar_1ton;
   logic          clk = 1'b0;
   logic          rst;
   tl_h2d_t       h_i;
   tl_d2h_t       h_o;
   tl_h2d_t       d_o [4];
   tl_d2h_t       d_i [4];
   logic [2:0]    outst;
   logic          unmapped;
   int            n_checks = 0;
   int            n_err = 0;

   tlul_xbar_1ton #(
      .NumDev(4),
      .MaxOutstanding(4),
      .DevBase('{32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h5000_0000}),
      .DevMask('{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_0000})
   ) dut (
      .clk_i(clk), .rst_i(rst), .tl_h_i(h_i), .tl_h_o(h_o),
      .tl_d_o(d_o), .tl_d_i(d_i), .outstanding_o(outst), .unmapped_o(unmapped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      h_i = '0;
      h_i.d_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d_i[i] = '0;
         d_i[i].a_ready = 1'b1;
      end
      #2;
      chk("rst_outst", outst, 0);
      chk("rst_dvalid", h_o.d_valid, 0);
      chk("rst_unmapped", unmapped, 0);
      chk("rst_dev0_dready", d_o[0].d_ready, 0);
      tick; tick;
      rst = 1'b0;

      // 1: Get to dev0, zero-latency routing both ways
      h_i.a_valid = 1'b1; h_i.a_opcode = 3'd4; h_i.a_address = 32'h1000_0010;
      h_i.a_source = 8'd1; h_i.a_size = 2'd2;
      #1;
      chk("t1_dev0_avalid", d_o[0].a_valid, 1);
      chk("t1_dev1_avalid", d_o[1].a_valid, 0);
      chk("t1_aready", h_o.a_ready, 1);
      chk("t1_outst0", outst, 0);
      tick;
      h_i.a_valid = 1'b0;
      d_i[0].d_valid = 1'b1; d_i[0].d_opcode = 3'd1; d_i[0].d_data = 32'h1234; d_i[0].d_source = 8'd1;
      #1;
      chk("t1_outst1", outst, 1);
      chk("t1_dvalid", h_o.d_valid, 1);
      chk("t1_ddata", h_o.d_data, 32'h1234);
      chk("t1_dev0_dready", d_o[0].d_ready, 1);
      tick;
      d_i[0].d_valid = 1'b0;
      #1;
      chk("t1_outst_end", outst, 0);

      // 2: four Gets to dev1 fill the window; fifth stalls
      h_i.d_ready = 1'b0;
      h_i.a_valid = 1'b1; h_i.a_address = 32'h2000_0000;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t2_aready_fill", h_o.a_ready, 1);
         tick;
      end
      #1;
      chk("t2_outst4", outst, 4);
      chk("t2_stall", h_o.a_ready, 0);
      chk("t2_dev1_avalid_stall", d_o[1].a_valid, 0);
      tick;
      chk("t2_outst4_hold", outst, 4);
      d_i[1].d_valid = 1'b1; d_i[1].d_opcode = 3'd1; d_i[1].d_data = 32'hBEEF;
      h_i.d_ready = 1'b1;
      #1;
      chk("t2_stall_full", h_o.a_ready, 0);
      chk("t2_dvalid", h_o.d_valid, 1);
      tick;
      chk("t2_outst3", outst, 3);
      chk("t2_aready_again", h_o.a_ready, 1);
      h_i.a_valid = 1'b0;
      tick; tick; tick;
      chk("t2_outst_drained", outst, 0);
      chk("t2_dvalid_gated", h_o.d_valid, 0);
      d_i[1].d_valid = 1'b0;

      // 3: Get dev0 in flight blocks a Put to dev1 until completion
      h_i.d_ready = 1'b0;
      h_i.a_valid = 1'b1; h_i.a_opcode = 3'd4; h_i.a_address = 32'h1000_0000;
      tick;
      h_i.a_opcode = 3'd0; h_i.a_address = 32'h2000_0004;
      #1;
      chk("t3_put_stall", h_o.a_ready, 0);
      chk("t3_dev1_avalid0", d_o[1].a_valid, 0);
      tick;
      chk("t3_outst1", outst, 1);
      d_i[0].d_valid = 1'b1; d_i[0].d_data = 32'hAAAA;
      h_i.d_ready = 1'b1;
      #1;
      chk("t3_first_rsp", h_o.d_data, 32'hAAAA);
      chk("t3_still_stall", h_o.a_ready, 0);
      tick;
      d_i[0].d_valid = 1'b0;
      #1;
      chk("t3_put_ready", h_o.a_ready, 1);
      chk("t3_dev1_avalid1", d_o[1].a_valid, 1);
      tick;
      h_i.a_valid = 1'b0;
      d_i[1].d_valid = 1'b1; d_i[1].d_opcode = 3'd0; d_i[1].d_data = 32'h0;
      #1;
      chk("t3_second_rsp_op", h_o.d_opcode, 0);
      chk("t3_second_rsp_valid", h_o.d_valid, 1);
      tick;
      d_i[1].d_valid = 1'b0;
      #1;
      chk("t3_outst_end", outst, 0);

      // 4: unmapped accesses go to the error responder
      h_i.d_ready = 1'b0;
      h_i.a_valid = 1'b1; h_i.a_opcode = 3'd4; h_i.a_address = 32'h3000_0000;
      h_i.a_source = 8'd5; h_i.a_size = 2'd2;
      #1;
      chk("t4_unmapped_pulse", unmapped, 1);
      chk("t4_aready", h_o.a_ready, 1);
      for (int i = 0; i < 4; i++) chk("t4_no_dev_avalid", d_o[i].a_valid, 0);
      tick;
      h_i.a_source = 8'd6; h_i.a_size = 2'd1;
      #1;
      chk("t4_unmapped_low", unmapped, 0);
      chk("t4_second_stall", h_o.a_ready, 0);
      chk("t4_err_dvalid", h_o.d_valid, 1);
      chk("t4_err_derror", h_o.d_error, 1);
      chk("t4_err_ddata", h_o.d_data, 32'hFFFF_FFFF);
      chk("t4_err_dsource", h_o.d_source, 5);
      chk("t4_err_dsize", h_o.d_size, 2);
      chk("t4_err_opcode", h_o.d_opcode, 1);
      tick;
      chk("t4_err_dvalid_held", h_o.d_valid, 1);
      h_i.a_valid = 1'b0; h_i.d_ready = 1'b1;
      tick;
      chk("t4_outst0", outst, 0);
      chk("t4_dvalid0", h_o.d_valid, 0);
      h_i.a_valid = 1'b1; h_i.a_opcode = 3'd1; h_i.a_source = 8'd7;
      #1;
      chk("t4_put_unmapped", unmapped, 1);
      tick;
      h_i.a_valid = 1'b0;
      #1;
      chk("t4_put_opcode", h_o.d_opcode, 0);
      chk("t4_put_source", h_o.d_source, 7);
      chk("t4_put_dvalid", h_o.d_valid, 1);
      tick;
      chk("t4_put_done", outst, 0);

      // 5: reset with three requests outstanding
      h_i.d_ready = 1'b0;
      h_i.a_valid = 1'b1; h_i.a_opcode = 3'd4; h_i.a_address = 32'h1000_0020;
      tick; tick; tick;
      h_i.a_valid = 1'b0;
      #1;
      chk("t5_outst3", outst, 3);
      rst = 1'b1;
      #1;
      chk("t5_rst_outst", outst, 0);
      chk("t5_rst_dvalid", h_o.d_valid, 0);
      d_i[0].d_valid = 1'b1; h_i.d_ready = 1'b1;
      #1;
      chk("t5_rst_dev0_dready", d_o[0].d_ready, 0);
      tick;
      rst = 1'b0;
      #1;
      chk("t5_late_dready", d_o[0].d_ready, 0);
      chk("t5_late_dvalid", h_o.d_valid, 0);
      d_i[0].d_valid = 1'b0;
      h_i.a_valid = 1'b1; h_i.a_address = 32'h2000_0008;
      #1;
      chk("t5_new_dev1", d_o[1].a_valid, 1);
      chk("t5_new_dev0", d_o[0].a_valid, 0);
      tick;
      h_i.a_valid = 1'b0;
      d_i[1].d_valid = 1'b1; d_i[1].d_opcode = 3'd1; d_i[1].d_data = 32'h55;
      #1;
      chk("t5_new_rsp", h_o.d_data, 32'h55);
      tick;
      d_i[1].d_valid = 1'b0;
      #1;
      chk("t5_outst_end", outst, 0);

      // 6: overlap priority and same-cycle accept + completion
      h_i.d_ready = 1'b0;
      h_i.a_valid = 1'b1; h_i.a_address = 32'h1000_0100;
      #1;
      chk("t6_dev0_sel", d_o[0].a_valid, 1);
      chk("t6_dev2_not_sel", d_o[2].a_valid, 0);
      tick;
      d_i[0].d_valid = 1'b1; d_i[0].d_data = 32'h77;
      h_i.d_ready = 1'b1;
      #1;
      chk("t6_aready", h_o.a_ready, 1);
      chk("t6_dvalid", h_o.d_valid, 1);
      tick;
      chk("t6_outst_unchanged", outst, 1);
      h_i.a_valid = 1'b0;
      tick;
      chk("t6_outst_end", outst, 0);
      d_i[0].d_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
